// File: rtl/rf_param_2r1w.sv
// rf_param_2r1w: parameterised register file, two registered read ports, one write port.
//
// Parameters:
//   WIDTH      data bits per register (1..64)
//   DEPTH      number of registers (2..256, need not be a power of two)
//   ZERO_REG0  1: register 0 reads as zero and ignores writes
//   ADDR_W     derived as $clog2(DEPTH); not overridable
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset; clears registers and read outputs
//   wrEn/wrAddr/wrVal   write request, address and data
//   rdEnA/rdAddrA       port-A read request and address
//   rdValA/rdValidA     port-A read data (held when idle) and one-cycle valid pulse
//   rdEnB/.../rdValidB  port B, identical to port A
//
// Build option:
//   RF_BYPASS_EN  defined: a read colliding with a write at the same edge returns
//                 the write data. Undefined: it returns the pre-write contents.

module rf_param_2r1w #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 8,
  parameter bit          ZERO_REG0 = 1'b0,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrVal,
  input  logic              rdEnA,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [WIDTH-1:0]  rdValA,
  output logic              rdValidA,
  input  logic              rdEnB,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [WIDTH-1:0]  rdValB,
  output logic              rdValidB
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] rd_val_a_d, rd_val_a_q;
  logic [WIDTH-1:0] rd_val_b_d, rd_val_b_q;
  logic             rd_valid_a_d, rd_valid_a_q;
  logic             rd_valid_b_d, rd_valid_b_q;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Address 0 is a hole when ZERO_REG0 is set: never written, always read as zero.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_REG0 && (a == '0);
  endfunction

  function automatic logic [WIDTH-1:0] read_sel(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (in_range(a) && !is_zero_reg(a)) begin
      v = regs_q[a];
`ifdef RF_BYPASS_EN
      if (wr_ok && (wrAddr == a)) begin
        v = wrVal;
      end
`endif
    end
    return v;
  endfunction

  always_comb begin
    wr_ok = wrEn && in_range(wrAddr) && !is_zero_reg(wrAddr);
  end

  // Idle ports hold their last data; only the valid flag drops.
  always_comb begin
    rd_val_a_d   = rd_val_a_q;
    rd_val_b_d   = rd_val_b_q;
    rd_valid_a_d = rdEnA;
    rd_valid_b_d = rdEnB;
    if (rdEnA) begin
      rd_val_a_d = read_sel(rdAddrA);
    end
    if (rdEnB) begin
      rd_val_b_d = read_sel(rdAddrB);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wrAddr] <= wrVal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_val_a_q   <= '0;
      rd_val_b_q   <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
    end else begin
      rd_val_a_q   <= rd_val_a_d;
      rd_val_b_q   <= rd_val_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
    end
  end

  assign rdValA   = rd_val_a_q;
  assign rdValB   = rd_val_b_q;
  assign rdValidA = rd_valid_a_q;
  assign rdValidB = rd_valid_b_q;

endmodule
